jellyvl_etherneco_packet_tx: RTL and testbench

- Frame generator that originates EtherNeco packets on a ring port.
- Serialises preamble, length, type, node, payload and FCS into the byte stream that feeds a node's packet receive/forward stage.
- Payload is pulled from a ready/valid source and the CRC32 FCS is appended automatically.
- Sits between the node's master/controller logic and the link TX path.

---
 rtl/jellyvl_etherneco_packet_tx.sv | 212 +++++++++++++++++++++
 tb/tb_jellyvl_etherneco_packet_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jellyvl_etherneco_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : jellyvl_etherneco_packet_tx
//  Brief    : EtherNeco frame generator (preamble, length, type, node,
//             payload, CRC32 FCS) with optional output register slice.
//  Revision : 1.0  initial release
// ============================================================================

module jellyvl_etherneco_packet_tx #(
  parameter int   GAP_CYCLES = 2,
  parameter logic M_REGS     = 1'b1
) (
  input  logic        reset,
  input  logic        clk,

  input  logic        tx_start,
  input  logic [15:0] tx_length,
  input  logic [7:0]  tx_type,
  input  logic [7:0]  tx_node,
  output logic        tx_busy,
  output logic        tx_done,

  input  logic [7:0]  s_payload_data,
  input  logic        s_payload_valid,
  output logic        s_payload_ready,

  output logic        m_tx_first,
  output logic        m_tx_last,
  output logic [7:0]  m_tx_data,
  output logic        m_tx_valid,
  input  logic        m_tx_ready
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_PREAMBLE = 3'd1;
  localparam logic [2:0] c_ST_LENGTH   = 3'd2;
  localparam logic [2:0] c_ST_TYPE     = 3'd3;
  localparam logic [2:0] c_ST_NODE     = 3'd4;
  localparam logic [2:0] c_ST_PAYLOAD  = 3'd5;
  localparam logic [2:0] c_ST_FCS      = 3'd6;
  localparam logic [2:0] c_ST_GAP      = 3'd7;

  localparam logic [15:0] c_GAP_LAST = 16'(GAP_CYCLES - 1);

  // Ethernet CRC-32, LSB-first; the register is kept un-inverted
  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_pay_cnt;
  logic [15:0] r_gap;
  logic [15:0] r_length;
  logic [7:0]  r_type;
  logic [7:0]  r_node;
  logic [31:0] r_crc;
  logic [31:0] w_fcs;

  logic        w_valid;
  logic        w_first;
  logic        w_last;
  logic [7:0]  w_data;
  logic        w_ready;
  logic        w_hs;
  logic        w_crc_en;
  logic        w_crc_first;

  assign w_hs        = w_valid & w_ready;
  assign w_fcs       = ~r_crc;
  assign tx_busy     = (r_state != c_ST_IDLE);
  assign w_crc_first = (r_state == c_ST_LENGTH) && (r_cnt == 4'd0);
  assign w_crc_en    = w_hs && ((r_state == c_ST_LENGTH) || (r_state == c_ST_TYPE) ||
                                (r_state == c_ST_NODE)   || (r_state == c_ST_PAYLOAD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:     if (tx_start) w_next = c_ST_PREAMBLE;
      c_ST_PREAMBLE: if (w_hs && r_cnt == 4'd7) w_next = c_ST_LENGTH;
      c_ST_LENGTH:   if (w_hs && r_cnt == 4'd1) w_next = c_ST_TYPE;
      c_ST_TYPE:     if (w_hs) w_next = c_ST_NODE;
      c_ST_NODE:     if (w_hs) w_next = c_ST_PAYLOAD;
      c_ST_PAYLOAD:  if (w_hs && r_pay_cnt == r_length) w_next = c_ST_FCS;
      c_ST_FCS:      if (w_hs && r_cnt == 4'd3) w_next = (GAP_CYCLES == 0) ? c_ST_IDLE : c_ST_GAP;
      c_ST_GAP:      if (r_gap == c_GAP_LAST) w_next = c_ST_IDLE;
      default:       w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid         = 1'b0;
    w_first         = 1'b0;
    w_last          = 1'b0;
    w_data          = 8'h00;
    s_payload_ready = 1'b0;
    tx_done         = 1'b0;
    case (r_state)
      c_ST_PREAMBLE: begin
        w_valid = 1'b1;
        w_first = (r_cnt == 4'd0);
        w_data  = (r_cnt == 4'd7) ? 8'hD5 : 8'h55;
      end
      c_ST_LENGTH: begin
        w_valid = 1'b1;
        w_data  = r_cnt[0] ? r_length[15:8] : r_length[7:0];
      end
      c_ST_TYPE: begin
        w_valid = 1'b1;
        w_data  = r_type;
      end
      c_ST_NODE: begin
        w_valid = 1'b1;
        w_data  = r_node;
      end
      c_ST_PAYLOAD: begin
        w_valid         = s_payload_valid;
        w_data          = s_payload_data;
        s_payload_ready = w_ready;
      end
      c_ST_FCS: begin
        w_valid = 1'b1;
        w_last  = (r_cnt == 4'd3);
        case (r_cnt[1:0])
          2'd0:    w_data = w_fcs[7:0];
          2'd1:    w_data = w_fcs[15:8];
          2'd2:    w_data = w_fcs[23:16];
          default: w_data = w_fcs[31:24];
        endcase
        tx_done = w_hs && (r_cnt == 4'd3);
      end
      default: ;
    endcase
  end

  // Counters and CRC only move on a byte handshake, so stalls hold everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 4'd0;
      r_pay_cnt <= 16'd0;
      r_gap     <= 16'd0;
      r_length  <= 16'd0;
      r_type    <= 8'd0;
      r_node    <= 8'd0;
      r_crc     <= 32'hFFFFFFFF;
    end else begin
      if (r_state == c_ST_IDLE && tx_start) begin
        r_length <= tx_length;
        r_type   <= tx_type;
        r_node   <= tx_node;
      end
      if (w_next != r_state) r_cnt <= 4'd0;
      else if (w_hs)         r_cnt <= r_cnt + 4'd1;
      if (r_state != c_ST_PAYLOAD) r_pay_cnt <= 16'd0;
      else if (w_hs)               r_pay_cnt <= r_pay_cnt + 16'd1;
      if (r_state != c_ST_GAP) r_gap <= 16'd0;
      else                     r_gap <= r_gap + 16'd1;
      if (w_crc_en) r_crc <= f_crc_byte(w_crc_first ? 32'hFFFFFFFF : r_crc, w_data);
    end
  end

  generate
    if (M_REGS) begin : g_m_regs
      logic       r_m_valid;
      logic       r_m_first;
      logic       r_m_last;
      logic [7:0] r_m_data;

      assign w_ready = !r_m_valid || m_tx_ready;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_m_valid <= 1'b0;
          r_m_first <= 1'b0;
          r_m_last  <= 1'b0;
          r_m_data  <= 8'h00;
        end else if (w_ready) begin
          r_m_valid <= w_valid;
          r_m_first <= w_first;
          r_m_last  <= w_last;
          r_m_data  <= w_data;
        end
      end

      assign m_tx_valid = r_m_valid;
      assign m_tx_first = r_m_first;
      assign m_tx_last  = r_m_last;
      assign m_tx_data  = r_m_data;
    end else begin : g_m_direct
      assign w_ready    = m_tx_ready;
      assign m_tx_valid = w_valid;
      assign m_tx_first = w_first;
      assign m_tx_last  = w_last;
      assign m_tx_data  = w_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_jellyvl_etherneco_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jellyvl_etherneco_packet_tx
//  Brief    : Self-checking bench with a queue-based frame model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_jellyvl_etherneco_packet_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_start = 1'b0;
  logic [15:0] tx_length = 16'd0;
  logic [7:0]  tx_type = 8'd0;
  logic [7:0]  tx_node = 8'd0;
  logic        tx_busy, tx_done;
  logic [7:0]  s_payload_data;
  logic        s_payload_valid;
  logic        s_payload_ready;
  logic        m_tx_first, m_tx_last, m_tx_valid;
  logic [7:0]  m_tx_data;
  logic        m_tx_ready;

  jellyvl_etherneco_packet_tx #(.GAP_CYCLES(2), .M_REGS(1'b1)) dut (
    .reset(reset), .clk(clk),
    .tx_start(tx_start), .tx_length(tx_length), .tx_type(tx_type), .tx_node(tx_node),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .s_payload_data(s_payload_data), .s_payload_valid(s_payload_valid), .s_payload_ready(s_payload_ready),
    .m_tx_first(m_tx_first), .m_tx_last(m_tx_last), .m_tx_data(m_tx_data),
    .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          len_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  cap[0:31];
  int          exp_pos = 0;
  logic [31:0] mon_crc = 32'h0;
  int          frames_done = 0;
  int          frames_started = 0;
  int          done_cnt = 0;
  int          pay_hs_cnt = 0;
  int          cyc = 0;
  int          last_done_cyc = -1000;
  int          start_gap = 0;
  bit          rnd_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_out = 10'd0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Standard zlib-style CRC-32 step
  function automatic logic [31:0] crc_next(input logic [31:0] st, input logic [7:0] b);
    logic [31:0] s;
    s = st ^ {24'h0, b};
    repeat (8) s = s[0] ? ((s >> 1) ^ 32'hEDB88320) : (s >> 1);
    return s;
  endfunction

  task automatic model_frame(input int len, input logic [7:0] typ, input logic [7:0] node,
                             input logic [7:0] seed, input logic [7:0] step);
    logic [31:0] st;
    logic [7:0]  b;
    logic [15:0] l16;
    l16 = 16'(len);
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    st = 32'hFFFFFFFF;
    exp_q.push_back(l16[7:0]);  st = crc_next(st, l16[7:0]);
    exp_q.push_back(l16[15:8]); st = crc_next(st, l16[15:8]);
    exp_q.push_back(typ);       st = crc_next(st, typ);
    exp_q.push_back(node);      st = crc_next(st, node);
    for (int i = 0; i <= len; i++) begin
      b = 8'(seed + i * step);
      exp_q.push_back(b);
      pay_q.push_back(b);
      st = crc_next(st, b);
    end
    st = ~st;
    exp_q.push_back(st[7:0]);
    exp_q.push_back(st[15:8]);
    exp_q.push_back(st[23:16]);
    exp_q.push_back(st[31:24]);
    len_q.push_back(len + 17);
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic [7:0] typ, input logic [7:0] node);
    int n;
    n = 0;
    while (tx_busy && n < 1000) begin @(posedge clk); #2; n++; end
    chk(!tx_busy, "idle_wait", 32'(tx_busy), 32'h0);
    tx_start = 1'b1; tx_length = len; tx_type = typ; tx_node = node;
    @(posedge clk); #2;
    tx_start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin @(posedge clk); #2; n++; end
    chk(frames_done >= target, "frame_timeout", 32'(frames_done), 32'(target));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Payload source and downstream ready
  initial begin
    bit p_hs;
    s_payload_valid = 1'b0;
    s_payload_data  = 8'h00;
    m_tx_ready      = 1'b1;
    forever begin
      @(negedge clk);
      p_hs = s_payload_valid && s_payload_ready;
      @(posedge clk); #1;
      if (p_hs && pay_q.size() > 0) void'(pay_q.pop_front());
      s_payload_valid = (pay_q.size() > 0) && (!rnd_mode || $urandom_range(0, 1) == 1);
      s_payload_data  = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
      m_tx_ready      = !rnd_mode || ($urandom_range(0, 1) == 1);
    end
  end

  // Output compare against the model queue
  initial begin
    logic [7:0] e;
    int         cl;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (tx_done) begin done_cnt++; last_done_cyc = cyc; end
        if (s_payload_valid && s_payload_ready) pay_hs_cnt++;
        if (prev_stall)
          chk(m_tx_valid && ({m_tx_first, m_tx_last, m_tx_data} == prev_out), "stall_hold",
              {21'h0, m_tx_valid, m_tx_first, m_tx_last, m_tx_data}, {21'h0, 1'b1, prev_out});
        prev_stall = m_tx_valid && !m_tx_ready;
        prev_out   = {m_tx_first, m_tx_last, m_tx_data};
        if (m_tx_valid && m_tx_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_byte", {24'h0, m_tx_data}, 32'h0);
          end else begin
            e  = exp_q.pop_front();
            cl = len_q[0];
            chk({m_tx_data, m_tx_first, m_tx_last} == {e, exp_pos == 0, exp_pos == cl - 1}, "byte",
                {exp_pos[15:0], 6'h0, m_tx_data, m_tx_first, m_tx_last},
                {exp_pos[15:0], 6'h0, e, exp_pos == 0, exp_pos == cl - 1});
            if (exp_pos < 32) cap[exp_pos] = m_tx_data;
            if (exp_pos == 0) begin frames_started++; start_gap = cyc - last_done_cyc; end
            if (exp_pos == 8)     mon_crc = crc_next(32'hFFFFFFFF, m_tx_data);
            else if (exp_pos > 8) mon_crc = crc_next(mon_crc, m_tx_data);
            if (exp_pos == cl - 1) begin
              chk(~mon_crc == 32'h2144df1c, "fcs_residue", ~mon_crc, 32'h2144df1c);
              frames_done++;
              exp_pos = 0;
              void'(len_q.pop_front());
            end else begin
              exp_pos++;
            end
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] lit_a[0:12];
    logic [7:0] lit_b[0:8];
    int f0, d0, n;
    lit_a = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h00, 8'h00, 8'h10, 8'h00, 8'hA5};
    lit_b = '{8'h03, 8'h00, 8'h22, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk(tx_busy == 1'b0,         "rst_busy",  32'(tx_busy), 32'h0);
    chk(tx_done == 1'b0,         "rst_done",  32'(tx_done), 32'h0);
    chk(s_payload_ready == 1'b0, "rst_sready", 32'(s_payload_ready), 32'h0);
    chk(m_tx_valid == 1'b0,      "rst_mvalid", 32'(m_tx_valid), 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Minimal frame, literal pin of the header bytes
    f0 = frames_done; d0 = done_cnt; pay_hs_cnt = 0;
    model_frame(0, 8'h10, 8'h00, 8'hA5, 8'h01);
    pulse_start(16'd0, 8'h10, 8'h00);
    wait_frames(f0 + 1, 200);
    for (int i = 0; i < 13; i++) chk(cap[i] == lit_a[i], "lit_a", {24'h0, cap[i]}, {24'h0, lit_a[i]});
    chk(pay_hs_cnt == 1, "pay_hs_a", 32'(pay_hs_cnt), 32'd1);
    chk(done_cnt - d0 == 1, "done_a", 32'(done_cnt - d0), 32'd1);

    // Four-byte payload, receiver-style field check
    f0 = frames_done; pay_hs_cnt = 0;
    model_frame(3, 8'h22, 8'h07, 8'h01, 8'h01);
    pulse_start(16'd3, 8'h22, 8'h07);
    wait_frames(f0 + 1, 200);
    for (int i = 0; i < 8; i++) chk(cap[8 + i] == lit_b[i], "lit_b", {24'h0, cap[8 + i]}, {24'h0, lit_b[i]});
    chk(pay_hs_cnt == 4, "pay_hs_b", 32'(pay_hs_cnt), 32'd4);

    // Random backpressure and payload underrun
    f0 = frames_done; d0 = done_cnt; pay_hs_cnt = 0; rnd_mode = 1'b1;
    model_frame(63, 8'h5A, 8'h3C, 8'h11, 8'h03);
    pulse_start(16'd63, 8'h5A, 8'h3C);
    wait_frames(f0 + 1, 3000);
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk(pay_hs_cnt == 64, "pay_hs_c", 32'(pay_hs_cnt), 32'd64);
    chk(done_cnt - d0 == 1, "done_c", 32'(done_cnt - d0), 32'd1);

    // tx_start held high: one frame per busy window, gap honoured
    f0 = frames_done; d0 = frames_started;
    model_frame(2, 8'h33, 8'h44, 8'h80, 8'h05);
    model_frame(2, 8'h33, 8'h44, 8'h80, 8'h05);
    tx_start = 1'b1; tx_length = 16'd2; tx_type = 8'h33; tx_node = 8'h44;
    n = 0;
    while (frames_started < d0 + 2 && n < 500) begin @(posedge clk); #2; n++; end
    tx_start = 1'b0;
    chk(frames_started >= d0 + 2, "second_start", 32'(frames_started), 32'(d0 + 2));
    chk(start_gap >= 3, "gap_cycles", 32'(start_gap), 32'd3);
    wait_frames(f0 + 2, 500);
    repeat (20) @(posedge clk);
    #2;
    chk(frames_started == d0 + 2, "one_per_busy", 32'(frames_started), 32'(d0 + 2));

    // Asynchronous reset in the middle of a payload
    model_frame(255, 8'h01, 8'h02, 8'h07, 8'h01);
    pulse_start(16'd255, 8'h01, 8'h02);
    n = 0;
    while (exp_pos < 40 && n < 300) begin @(posedge clk); #2; n++; end
    chk(exp_pos >= 40, "reach_payload", 32'(exp_pos), 32'd40);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk(m_tx_valid == 1'b0, "async_mvalid", 32'(m_tx_valid), 32'h0);
    chk(tx_busy == 1'b0,    "async_busy",   32'(tx_busy), 32'h0);
    exp_q.delete(); len_q.delete(); pay_q.delete(); exp_pos = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    f0 = frames_done;
    model_frame(10, 8'h66, 8'h09, 8'h40, 8'h07);
    pulse_start(16'd10, 8'h66, 8'h09);
    wait_frames(f0 + 1, 200);

    // Maximum payload length
    f0 = frames_done; d0 = done_cnt; pay_hs_cnt = 0;
    model_frame(65535, 8'h77, 8'h88, 8'h00, 8'h01);
    pulse_start(16'hFFFF, 8'h77, 8'h88);
    wait_frames(f0 + 1, 70000);
    chk(pay_hs_cnt == 65536, "pay_hs_max", 32'(pay_hs_cnt), 32'd65536);
    chk(done_cnt - d0 == 1, "done_max", 32'(done_cnt - d0), 32'd1);

    repeat (5) @(posedge clk);
    #2;
    chk(exp_q.size() == 0, "model_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
